// File: rtl/icache_prefetch_gen_pkg.sv
// Shared types and constants for the icache next-line prefetch generator.
// Contents: pc_req_t request payload, cache line/page offset widths,
// pf_state_e generator FSM encoding, 32-bit saturating add helper.
package icache_prefetch_gen_pkg;

  localparam int unsigned PC_ADDR_W            = 48;
  localparam int unsigned ICACHE_LINE_OFFSET_W = 6;
  localparam int unsigned ICACHE_PAGE_OFFSET_W = 12;

  // Fetch request payload shared by demand and prefetch channels
  typedef struct packed {
    logic [PC_ADDR_W-1:0] pc;
    logic [1:0]           thread_id;
    logic                 is_spec;
  } pc_req_t;

  typedef enum logic {
    IDLE = 1'b0,
    GEN  = 1'b1
  } pf_state_e;

  // Saturating 32-bit accumulate for statistics counters
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/icache_pf_fifo.sv
// Synchronous prefetch queue of pc_req_t, organised as a shift queue so the
// head entry and its valid bit come straight from flops.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           drop every entry next cycle
//   push, push_pld  enqueue (ignored when full unless popping the same cycle)
//   pop             dequeue head (caller qualifies with head_vld)
//   full            all slots occupied
//   head_vld        queue not empty
//   head_pld        head entry
//   occupancy_c     live entry count (only with ICACHE_PF_STAT_EN)
module icache_pf_fifo
  import icache_prefetch_gen_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    flush,
  input  logic    push,
  input  pc_req_t push_pld,
  input  logic    pop,
  output logic    full,
  output logic    head_vld,
  output pc_req_t head_pld
`ifdef ICACHE_PF_STAT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_c
`endif
);

  pc_req_t          mem_q  [DEPTH];
  logic [DEPTH-1:0] vld_q;
  pc_req_t          sh_mem [DEPTH];
  logic [DEPTH-1:0] sh_vld;
  pc_req_t          mem_d  [DEPTH];
  logic [DEPTH-1:0] vld_d;
  logic             placed;

  // Shift out the popped head, then drop the push into the first free slot
  always_comb begin
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      sh_mem[i] = pop ? mem_q[i+1] : mem_q[i];
      sh_vld[i] = pop ? vld_q[i+1] : vld_q[i];
    end
    sh_mem[DEPTH-1] = pop ? '0   : mem_q[DEPTH-1];
    sh_vld[DEPTH-1] = pop ? 1'b0 : vld_q[DEPTH-1];

    mem_d  = sh_mem;
    vld_d  = sh_vld;
    placed = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (push && !placed && !sh_vld[i]) begin
        mem_d[i] = push_pld;
        vld_d[i] = 1'b1;
        placed   = 1'b1;
      end
    end
  end

  // Storage; flush clears contents like reset
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
    end
  end

  assign full     = vld_q[DEPTH-1];
  assign head_vld = vld_q[0];
  assign head_pld = mem_q[0];

`ifdef ICACHE_PF_STAT_EN
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  // Valid bits are contiguous from slot 0, so popcount is the occupancy
  always_comb begin
    occupancy_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      occupancy_c = occupancy_c + OCC_W'(vld_q[i]);
    end
  end
`endif

endmodule

// File: rtl/icache_prefetch_gen.sv
// Next-line instruction prefetch generator feeding the icache arbiter's
// lowest-priority prefetch channel. Each accepted demand fetch to a new line
// queues up to PF_DEGREE sequential line addresses, never crossing a 4KB page.
// Optional statistics: define ICACHE_PF_STAT_EN to add pf_issue_cnt/pf_drop_cnt.
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   demand_fire_vld, demand_fire_pld   demand request accepted by tag stage
//   flush                              drop all prefetch work
//   prefetch_req_vld/rdy/pld           prefetch request channel to arbiter
//   pf_issue_cnt, pf_drop_cnt          saturating stats (ICACHE_PF_STAT_EN)
module icache_prefetch_gen
  import icache_prefetch_gen_pkg::*;
#(
  parameter int unsigned PF_DEGREE      = 2,
  parameter int unsigned PF_QUEUE_DEPTH = 4,
  parameter int unsigned ADDR_WIDTH     = 48
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    demand_fire_vld,
  input  pc_req_t demand_fire_pld,
  input  logic    flush,
  output logic    prefetch_req_vld,
  input  logic    prefetch_req_rdy,
  output pc_req_t prefetch_req_pld
`ifdef ICACHE_PF_STAT_EN
  ,
  output logic [31:0] pf_issue_cnt,
  output logic [31:0] pf_drop_cnt
`endif
);

  localparam int unsigned LINE_W      = ADDR_WIDTH - ICACHE_LINE_OFFSET_W;
  localparam int unsigned PAGE_LINE_W = ICACHE_PAGE_OFFSET_W - ICACHE_LINE_OFFSET_W;
  localparam int unsigned CNT_W       = $clog2(PF_DEGREE + 1);

  pf_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] base_q, base_d;
  logic [LINE_W-1:0] last_line_q, last_line_d;
  logic              last_vld_q, last_vld_d;

  logic [LINE_W-1:0] fire_line_c;
  logic [LINE_W-1:0] target_c;
  logic              trigger_c;
  logic              cross_c;
  logic              push_c;
  logic              guard_c;
  logic              pop_c;
  logic              fifo_full;
  pc_req_t           push_pld_c;

  // Only the line index of the demand pc matters here
  logic unused_demand_bits_c;
  assign unused_demand_bits_c = ^{demand_fire_pld.thread_id, demand_fire_pld.is_spec,
                                  demand_fire_pld.pc[ICACHE_LINE_OFFSET_W-1:0]};

  assign fire_line_c = demand_fire_pld.pc[ADDR_WIDTH-1:ICACHE_LINE_OFFSET_W];
  // Flush wins over a same-cycle trigger; repeat fires to the last line are filtered
  assign trigger_c   = demand_fire_vld && !flush &&
                       (!last_vld_q || (fire_line_c != last_line_q));
  assign target_c    = base_q + LINE_W'(cnt_q);
  assign cross_c     = target_c[LINE_W-1:PAGE_LINE_W] != base_q[LINE_W-1:PAGE_LINE_W];
  assign pop_c       = prefetch_req_vld && prefetch_req_rdy;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      last_line_q <= '0;
      last_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      last_line_q <= last_line_d;
      last_vld_q  <= last_vld_d;
    end
  end

  // Next state: a trigger restarts generation after this cycle's push completes
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    last_line_d = last_line_q;
    last_vld_d  = last_vld_q;
    if (flush) begin
      state_d    = IDLE;
      last_vld_d = 1'b0;
    end else if (trigger_c) begin
      state_d     = GEN;
      cnt_d       = CNT_W'(1);
      base_d      = fire_line_c;
      last_line_d = fire_line_c;
      last_vld_d  = 1'b1;
    end else if (state_q == GEN) begin
      if (guard_c) begin
        state_d = IDLE;
      end else if (push_c) begin
        if (cnt_q == CNT_W'(PF_DEGREE)) state_d = IDLE;
        else                            cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  // Outputs: push a target when there is room (a same-cycle pop frees a slot)
  always_comb begin
    push_c     = 1'b0;
    guard_c    = 1'b0;
    push_pld_c = '0;
    push_pld_c.pc = PC_ADDR_W'({target_c, {ICACHE_LINE_OFFSET_W{1'b0}}});
    if ((state_q == GEN) && !flush) begin
      if (cross_c)                   guard_c = 1'b1;
      else if (!fifo_full || pop_c)  push_c  = 1'b1;
    end
  end

`ifdef ICACHE_PF_STAT_EN
  logic [$clog2(PF_QUEUE_DEPTH+1)-1:0] occupancy_c;
`endif

  icache_pf_fifo #(
    .DEPTH (PF_QUEUE_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (push_c),
    .push_pld (push_pld_c),
    .pop      (pop_c),
    .full     (fifo_full),
    .head_vld (prefetch_req_vld),
    .head_pld (prefetch_req_pld)
`ifdef ICACHE_PF_STAT_EN
    ,
    .occupancy_c (occupancy_c)
`endif
  );

`ifdef ICACHE_PF_STAT_EN
  logic [CNT_W-1:0] remain_c;
  logic [31:0]      drop_inc_c;

  // Targets still owed by the generator, including the one at cnt
  always_comb begin
    remain_c   = (state_q == GEN) ? (CNT_W'(PF_DEGREE) - cnt_q + CNT_W'(1)) : '0;
    drop_inc_c = '0;
    if (flush) begin
      drop_inc_c = 32'(remain_c) + 32'(occupancy_c) - 32'(pop_c);
    end else if (guard_c) begin
      drop_inc_c = 32'd1;
    end else if (trigger_c && (state_q == GEN)) begin
      drop_inc_c = 32'(remain_c) - 32'(push_c);
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      pf_issue_cnt <= '0;
      pf_drop_cnt  <= '0;
    end else begin
      pf_issue_cnt <= sat_add32(pf_issue_cnt, 32'(pop_c));
      pf_drop_cnt  <= sat_add32(pf_drop_cnt, drop_inc_c);
    end
  end
`endif

endmodule

// File: tb/tb_icache_prefetch_gen.sv
// Bench for icache_prefetch_gen: directed scenarios followed by random traffic,
// all compared each cycle against a queue-based reference model.
module tb_icache_prefetch_gen;
  import icache_prefetch_gen_pkg::*;

  localparam int unsigned DEG   = 2;
  localparam int unsigned DEPTH = 4;

  logic    clk = 1'b0;
  logic    rst;
  logic    demand_fire_vld;
  pc_req_t demand_fire_pld;
  logic    flush;
  logic    prefetch_req_vld;
  logic    prefetch_req_rdy;
  pc_req_t prefetch_req_pld;
`ifdef ICACHE_PF_STAT_EN
  logic [31:0] pf_issue_cnt;
  logic [31:0] pf_drop_cnt;
`endif

  always #5 clk = ~clk;

  icache_prefetch_gen #(
    .PF_DEGREE      (DEG),
    .PF_QUEUE_DEPTH (DEPTH),
    .ADDR_WIDTH     (48)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .demand_fire_vld  (demand_fire_vld),
    .demand_fire_pld  (demand_fire_pld),
    .flush            (flush),
    .prefetch_req_vld (prefetch_req_vld),
    .prefetch_req_rdy (prefetch_req_rdy),
    .prefetch_req_pld (prefetch_req_pld)
`ifdef ICACHE_PF_STAT_EN
    ,
    .pf_issue_cnt     (pf_issue_cnt),
    .pf_drop_cnt      (pf_drop_cnt)
`endif
  );

  // Reference model: queued addresses plus list of still-to-generate targets
  logic [47:0] mq[$];
  logic [47:0] pend[$];
  logic [41:0] m_last;
  logic        m_last_vld;
  int unsigned m_issue;
  int          total;
  int          bad;

  task automatic model_edge(input logic f, input logic [47:0] pc, input logic fl,
                            input logic rdy, input logic r);
    logic [41:0] line;
    logic [41:0] t;
    logic        popped;
    int          occ;
    line = pc[47:6];
    if (r) begin
      mq.delete(); pend.delete(); m_last_vld = 1'b0; m_last = '0; m_issue = 0;
      return;
    end
    popped = (mq.size() != 0) && rdy;
    occ    = mq.size();
    if (popped) begin
      void'(mq.pop_front());
      m_issue++;
    end
    if (fl) begin
      mq.delete(); pend.delete(); m_last_vld = 1'b0;
      return;
    end
    if ((pend.size() != 0) && ((occ < int'(DEPTH)) || popped)) mq.push_back(pend.pop_front());
    if (f && (!m_last_vld || (line != m_last))) begin
      pend.delete();
      for (int k = 1; k <= int'(DEG); k++) begin
        t = line + 42'(k);
        if (t[41:6] != line[41:6]) break;
        pend.push_back({t, 6'b0});
      end
      m_last     = line;
      m_last_vld = 1'b1;
    end
  endtask

  task automatic check_outputs();
    logic ev;
    ev = (mq.size() != 0);
    total++;
    assert (prefetch_req_vld === ev) else begin
      bad++;
      $error("FAIL vld: observed=%b expected=%b t=%0t", prefetch_req_vld, ev, $time);
    end
    if (ev) begin
      total++;
      assert (prefetch_req_pld.pc === mq[0]) else begin
        bad++;
        $error("FAIL pld_pc: observed=%h expected=%h t=%0t", prefetch_req_pld.pc, mq[0], $time);
      end
      total++;
      assert ({prefetch_req_pld.thread_id, prefetch_req_pld.is_spec} === 3'b000) else begin
        bad++;
        $error("FAIL pld_side: observed=%b expected=000 t=%0t",
               {prefetch_req_pld.thread_id, prefetch_req_pld.is_spec}, $time);
      end
    end
`ifdef ICACHE_PF_STAT_EN
    total++;
    assert (pf_issue_cnt === 32'(m_issue)) else begin
      bad++;
      $error("FAIL issue_cnt: observed=%0d expected=%0d", pf_issue_cnt, m_issue);
    end
`endif
  endtask

  task automatic step(input logic f, input logic [47:0] pc, input logic fl, input logic rdy);
    demand_fire_vld           = f;
    demand_fire_pld           = '0;
    demand_fire_pld.pc        = pc;
    demand_fire_pld.thread_id = 2'($urandom);
    demand_fire_pld.is_spec   = 1'($urandom);
    flush                     = fl;
    prefetch_req_rdy          = rdy;
    @(posedge clk);
    model_edge(f, pc, fl, rdy, rst);
    #1;
    check_outputs();
  endtask

  task automatic expect_head(input string tag, input logic [47:0] pc);
    total++;
    assert ((prefetch_req_vld === 1'b1) && (prefetch_req_pld.pc === pc)) else begin
      bad++;
      $error("FAIL %s: observed vld=%b pc=%h expected vld=1 pc=%h",
             tag, prefetch_req_vld, prefetch_req_pld.pc, pc);
    end
  endtask

  task automatic expect_idle(input string tag);
    total++;
    assert (prefetch_req_vld === 1'b0) else begin
      bad++;
      $error("FAIL %s: observed vld=%b expected vld=0", tag, prefetch_req_vld);
    end
  endtask

  task automatic expect_zero_pld(input string tag);
    total++;
    assert (prefetch_req_pld === pc_req_t'('0)) else begin
      bad++;
      $error("FAIL %s: observed pld=%h expected pld=0", tag, prefetch_req_pld);
    end
  endtask

  initial begin
    logic [47:0] rpc;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    demand_fire_vld  = 1'b0;
    demand_fire_pld  = '0;
    flush            = 1'b0;
    prefetch_req_rdy = 1'b0;

    // Reset state
    step(0, 48'h0, 0, 0);
    step(1, 48'h1000, 0, 1);
    rst = 1'b0;
    expect_idle("reset_vld");
    expect_zero_pld("reset_pld");

    // Single trigger: first prefetch two cycles after the fire
    step(1, 48'h1000, 0, 1);
    expect_idle("single_t1");
    step(0, 48'h0, 0, 1);
    expect_head("single_t2", 48'h1040);
    step(0, 48'h0, 0, 1);
    expect_head("single_t3", 48'h1080);
    step(0, 48'h0, 0, 1);
    expect_idle("single_end");

    // Duplicate filter after clearing last_line with a flush
    step(0, 48'h0, 1, 1);
    step(1, 48'h1000, 0, 1);
    step(1, 48'h1010, 0, 1);
    expect_head("dup_first", 48'h1040);
    step(0, 48'h0, 0, 1);
    expect_head("dup_second", 48'h1080);
    step(0, 48'h0, 0, 1);
    expect_idle("dup_end");
    step(0, 48'h0, 0, 1);
    expect_idle("dup_end2");

    // Page guard: next line is in the following 4KB page
    step(1, 48'h1FC0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 48'h0, 0, 1);
      expect_idle("page_guard");
    end

    // Backpressure: fill the queue, hold pld stable, then drain
    step(1, 48'h0, 0, 0);
    step(0, 48'h0, 0, 0);
    step(0, 48'h0, 0, 0);
    step(1, 48'h3000, 0, 0);
    step(0, 48'h0, 0, 0);
    step(0, 48'h0, 0, 0);
    step(1, 48'h5000, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 48'h0, 0, 0);
      expect_head("bp_hold", 48'h40);
    end
    for (int i = 0; i < 8; i++) step(0, 48'h0, 0, 1);
    expect_idle("bp_drained");

    // Restart: second trigger abandons the old base's remaining target
    step(0, 48'h0, 1, 1);
    step(1, 48'h0, 0, 1);
    step(1, 48'h4000, 0, 1);
    expect_head("restart_0", 48'h40);
    step(0, 48'h0, 0, 1);
    expect_head("restart_1", 48'h4040);
    step(0, 48'h0, 0, 1);
    expect_head("restart_2", 48'h4080);
    step(0, 48'h0, 0, 1);
    expect_idle("restart_end");

    // Flush with two entries queued, then re-trigger on the same line
    step(1, 48'h3000, 0, 0);
    step(0, 48'h0, 0, 0);
    step(0, 48'h0, 0, 0);
    expect_head("flush_pre", 48'h3040);
    step(0, 48'h0, 1, 0);
    expect_idle("flush_vld");
    step(1, 48'h3000, 0, 1);
    step(0, 48'h0, 0, 1);
    expect_head("flush_retrig", 48'h3040);

    // Reset mid-operation
    step(1, 48'h7000, 0, 0);
    step(0, 48'h0, 0, 0);
    rst = 1'b1;
    step(1, 48'h9000, 1, 1);
    rst = 1'b0;
    expect_idle("midrst_vld");
    expect_zero_pld("midrst_pld");

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      rpc = 48'(($urandom_range(0, 3) << 12) |
                (($urandom_range(0, 1) != 0 ? $urandom_range(58, 63) : $urandom_range(0, 63)) << 6) |
                $urandom_range(0, 63));
      rst = ($urandom_range(0, 199) == 0);
      step(($urandom_range(0, 9) < 4), rpc, ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 6));
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
